vc_arbiter: RTL
===============

Name: vc_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Pops one word per cycle from the winning VC and steers it into D0 or D1 by a destination bit in the word.
- Honours destination almost_full flags; runs only while the control FSM reports active.
- Reports idle back to the FSM when no traffic is pending.

Parameters:
- DATA_W, 6, width of a data word.
- DEST_BIT, 4, bit index selecting destination (0 -> D0, 1 -> D1).
- STARVE_LIMIT, 4, consecutive VC0 grants before a forced VC1 grant (used only with the optional feature).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- active  input  1  FSM active state; arbitration allowed only when 1.
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  DATA_W  VC0 head word (show-ahead, valid when !vc0_empty).
- vc1_data  input  DATA_W  VC1 head word (show-ahead).
- d0_almost_full  input  1  D0 FIFO almost full.
- d1_almost_full  input  1  D1 FIFO almost full.
- vc0_pop  output  1  pop VC0 this cycle (combinational from registered state and inputs).
- vc1_pop  output  1  pop VC1 this cycle.
- d0_push  output  1  registered push into D0.
- d1_push  output  1  registered push into D1.
- data_out  output  DATA_W  registered word to D0/D1.
- arb_idle  output  1  registered; no grant issued and no push in flight.

Behaviour:
- Reset (reset=1 at posedge): all registered outputs 0, data_out=0, arb_idle=1, state=IDLE, starve counter=0.
- Eligibility:
  - VCn is eligible when !vcn_empty and the destination of vcn_data[DEST_BIT] is not almost_full.
  - Eligibility is evaluated per VC, so a blocked VC0 head does not block an eligible VC1.
- Grant:
  - Only when active=1, state!=HALT, and at least one VC is eligible.
  - VC0 has strict priority over VC1.
  - At most one pop per cycle; vc0_pop and vc1_pop are never both 1.
- Latency:
  - Pop in cycle N; in cycle N+1, data_out holds the popped word and exactly one of d0_push/d1_push is 1.
  - Throughput is one word per cycle.
  - Almost-full thresholds are set by the FSM umbrales to tolerate one in-flight push; the arbiter does not compensate.
- Push outputs are 0 in any cycle N+1 not preceded by a grant in cycle N. data_out holds its last value when there is no push.
- FSM states:
  - IDLE: no grant. Go to SERVE on an eligible VC with active=1.
  - SERVE: grant issued this cycle. Stay while eligible and active=1. Go to IDLE when nothing is eligible. Go to HALT when active falls.
  - HALT: no new grants; the in-flight push still completes in the next cycle. Go to IDLE when active=1 again.
- arb_idle=1 when state is IDLE or HALT, both VCs are empty, and no push is pending. It updates one cycle after the condition.
- active deasserted mid-burst: the word popped in the previous cycle is still pushed; no further pops.
- Both destinations almost full: no pops, state IDLE, arb_idle stays 0 while VC data remains.
- Reset mid-operation: any pending push is dropped (d0_push/d1_push=0 the next cycle). Upstream FIFOs are reset by the same reset.

Optional Feature:
- Macro: VC_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter tracks consecutive VC0 grants made while VC1 was eligible.
  - When the counter reaches STARVE_LIMIT, the next cycle grants VC1 if VC1 is eligible, and the counter clears.
  - The counter also clears on any VC1 grant and on any cycle with VC1 not eligible.
- Not defined: strict VC0 priority only; no counter logic is synthesised.

Test Plan:
- Reset: reset=1 for 2 cycles with both VCs non-empty -> all pops/pushes 0, data_out=0, arb_idle=1.
- Priority: active=1, vc0_data=6'h05 (dest 0), vc1_data=6'h15 (dest 1), neither almost full -> vc0_pop cycle N; d0_push=1, data_out=6'h05 in N+1; vc1_pop only after vc0_empty=1.
- Per-VC blocking: vc0_data=6'h13 (dest 1), d1_almost_full=1, vc1_data=6'h02 (dest 0) -> vc1_pop=1, d0_push=1 next cycle with data_out=6'h02, vc0_pop stays 0.
- Halt: active drops the cycle after a VC1 grant -> push still occurs next cycle; no pops while active=0; state returns to IDLE when active=1.
- Idle flag: both VCs drained -> arb_idle=1 one cycle after last push; reset asserted mid-burst -> push next cycle is 0.
- With VC_STARVE_GUARD_EN: both VCs continuously eligible, STARVE_LIMIT=4 -> grant pattern VC0×4, VC1×1, repeating.

Source files
------------

// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC FIFOs / destination FIFOs / control FSM and vc_arbiter.
// master = environment side (FIFOs and FSM), slave = the arbiter.
interface vc_arbiter_if #(
  parameter int DATA_W = 6
);
  logic              active;
  logic              vc0_empty;
  logic              vc1_empty;
  logic [DATA_W-1:0] vc0_data;
  logic [DATA_W-1:0] vc1_data;
  logic              d0_almost_full;
  logic              d1_almost_full;
  logic              vc0_pop;
  logic              vc1_pop;
  logic              d0_push;
  logic              d1_push;
  logic [DATA_W-1:0] data_out;
  logic              arb_idle;

  // Pop is a same-cycle request against a show-ahead head: a word is consumed on
  // every rising edge where vcN_pop=1; the push side is registered, one cycle later.
  modport master (
    output active, vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle
  );

  modport slave (
    input  active, vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, arb_idle
  );
endinterface

// File: rtl/vc_arbiter.sv
// Two-VC to two-destination scheduler: one pop per cycle, registered push one cycle later.
// Optional VC1 anti-starvation guard enabled by defining VC_STARVE_GUARD_EN.
module vc_arbiter #(
  parameter int DATA_W       = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  vc_arbiter_if.slave    bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              vc0_elig, vc1_elig;
  logic              grant_ok;
  logic              gnt0, gnt1, grant;
  logic [DATA_W-1:0] win_data;
  logic              d0_push_q, d0_push_d;
  logic              d1_push_q, d1_push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              idle_q, idle_d;

  // Eligibility is judged per VC so a blocked VC0 head never stalls VC1.
  always_comb begin
    vc0_elig = !bus.vc0_empty &&
               !(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
    vc1_elig = !bus.vc1_empty &&
               !(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
    grant_ok = !reset && bus.active && (state_q != ST_HALT);
  end

`ifdef VC_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;
  logic       force_vc1;

  always_comb begin
    force_vc1 = (starve_q == 4'(STARVE_LIMIT));
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (grant_ok) begin
      if (force_vc1 && vc1_elig) begin
        gnt1 = 1'b1;
      end else if (vc0_elig) begin
        gnt0 = 1'b1;
      end else if (vc1_elig) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Counts back-to-back VC0 wins that were taken while VC1 could have gone.
  always_comb begin
    starve_d = starve_q;
    if (!vc1_elig || gnt1) begin
      starve_d = 4'd0;
    end else if (gnt0) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_ok) begin
      if (vc0_elig) begin
        gnt0 = 1'b1;
      end else if (vc1_elig) begin
        gnt1 = 1'b1;
      end
    end
  end
`endif

  assign grant = gnt0 | gnt1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SERVE means a grant was issued in the previous cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (!bus.active)  state_d = ST_HALT;
        else if (grant)   state_d = ST_SERVE;
        else              state_d = ST_IDLE;
      end
      ST_HALT: begin
        if (bus.active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: combinational pops, next values for the registered push side.
  always_comb begin
    bus.vc0_pop = gnt0;
    bus.vc1_pop = gnt1;
    win_data    = gnt1 ? bus.vc1_data : bus.vc0_data;
    d0_push_d   = grant && !win_data[DEST_BIT];
    d1_push_d   = grant &&  win_data[DEST_BIT];
    data_d      = grant ? win_data : data_q;
    // With no grant now the next state is IDLE or HALT and nothing is in flight next cycle.
    idle_d      = !grant && (state_d != ST_SERVE) && bus.vc0_empty && bus.vc1_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      data_q    <= '0;
      idle_q    <= 1'b1;
    end else begin
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.d0_push  = d0_push_q;
  assign bus.d1_push  = d1_push_q;
  assign bus.data_out = data_q;
  assign bus.arb_idle = idle_q;
  assign state_o      = state_q;

endmodule
